axi_cmd_arbiter: RTL

AXI_CMD_ARBITER -- requirements
Module: axi_cmd_arbiter

---
 rtl/axi_arb_pkg.sv | 35 +++
 rtl/axi_cmd_arbiter_if.sv | 51 +++++
 rtl/rr_arbiter.sv | 28 ++
 rtl/axi_cmd_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI command arbiter: FSM encoding, AXI burst and
// response codes, the latched command attributes, and the 4 KB boundary helper.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } arb_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef struct packed {
    logic       write;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } cmd_attr_t;

  // 17 bits holds 0xFFF + 256*128 without overflow for any len/size encoding.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size);
    logic [16:0] nbytes;
    nbytes = (17'(len) + 17'd1) << size;
    return (17'(addr_lo) + nbytes) > 17'd4096;
  endfunction

endpackage

// File: rtl/axi_cmd_arbiter_if.sv
// Requester-side and AXI-master-side command signals of the arbiter.
// Handshakes: a transfer happens in the cycle where valid and ready are both high;
// valid must not depend on ready and the command is held stable until then.
interface axi_cmd_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 4,
    parameter int SRCW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_write;
    logic [NREQ-1:0][WIDTH-1:0] req_addr;
    logic [NREQ-1:0][7:0]       req_len;
    logic [NREQ-1:0][2:0]       req_size;
    logic [NREQ-1:0][1:0]       req_burst;
    logic [NREQ-1:0][IDW-1:0]   req_id;

    logic                       m_valid;
    logic                       m_ready;
    logic                       m_write;
    logic [WIDTH-1:0]           m_addr;
    logic [7:0]                 m_len;
    logic [2:0]                 m_size;
    logic [1:0]                 m_burst;
    logic [IDW-1:0]             m_id;
    logic [SRCW-1:0]            m_src;
    logic                       m_done;
    logic [1:0]                 m_resp;

    logic [NREQ-1:0]            rsp_valid;
    logic                       rsp_err;

    // Arbiter view.
    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_size, req_burst, req_id,
        output req_ready,
        output m_valid, m_write, m_addr, m_len, m_size, m_burst, m_id, m_src,
        input  m_ready, m_done, m_resp,
        output rsp_valid, rsp_err
    );

    // Environment view: requesters plus the downstream AXI master.
    modport master (
        output req_valid, req_write, req_addr, req_len, req_size, req_burst, req_id,
        input  req_ready,
        input  m_valid, m_write, m_addr, m_len, m_size, m_burst, m_id, m_src,
        output m_ready, m_done, m_resp,
        input  rsp_valid, rsp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: the search starts one past last_grant and wraps around.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_any
);
    logic [IDXW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDXW'((int'(last_grant) + i) % NREQ);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter funnelling NREQ command requesters onto one AXI command port.
// Define AXI_ARB_4K_CHECK_EN to reject INCR bursts that cross a 4 KB boundary.
module axi_cmd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 4
) (
    input  logic                clk,
    input  logic                reset,
    axi_cmd_arbiter_if.slave    bus,
    output logic [1:0]          dbg_state
);
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] ERR   = ST_ERR;

    logic [1:0]       state;
    logic [SRCW-1:0]  last_grant;
    logic [SRCW-1:0]  grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic             grant_any;
    logic             hs;
    logic             to_err;
    cmd_attr_t        attr_sel;

    logic [SRCW-1:0]  src_q;
    cmd_attr_t        attr_q;
    logic [WIDTH-1:0] addr_q;
    logic [IDW-1:0]   id_q;

    logic             done_ok;
    logic             err_pulse;

    rr_arbiter #(.NREQ(NREQ), .IDXW(SRCW)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant_oh),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign hs            = (state == IDLE) && grant_any && !reset;
    assign bus.req_ready = hs ? grant_oh : '0;

    always_comb begin
        attr_sel       = '0;
        attr_sel.write = bus.req_write[grant_idx];
        attr_sel.len   = bus.req_len[grant_idx];
        attr_sel.size  = bus.req_size[grant_idx];
        attr_sel.burst = bus.req_burst[grant_idx];
    end

`ifdef AXI_ARB_4K_CHECK_EN
    assign to_err = (attr_sel.burst == BURST_RSVD) ||
                    ((attr_sel.burst == BURST_INCR) &&
                     crosses_4k(bus.req_addr[grant_idx][11:0], attr_sel.len, attr_sel.size));
`else
    assign to_err = (attr_sel.burst == BURST_RSVD);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= SRCW'(NREQ - 1);
            src_q      <= '0;
            attr_q     <= '0;
            addr_q     <= '0;
            id_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        src_q      <= grant_idx;
                        attr_q     <= attr_sel;
                        addr_q     <= bus.req_addr[grant_idx];
                        id_q       <= bus.req_id[grant_idx];
                        last_grant <= grant_idx;
                        state      <= to_err ? ERR : ISSUE;
                    end
                end
                ISSUE:   if (bus.m_ready) state <= WAIT;
                WAIT:    if (bus.m_done)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is reported in the same cycle as m_done (or the ERR cycle); a
    // reset in that cycle suppresses it so the dropped command never responds.
    assign done_ok   = !reset && (state == WAIT) && bus.m_done;
    assign err_pulse = !reset && (state == ERR);

    assign bus.rsp_valid = (done_ok || err_pulse) ? (NREQ'(1) << src_q) : '0;
    assign bus.rsp_err   = err_pulse || (done_ok && (bus.m_resp != RESP_OKAY));

    assign bus.m_valid = !reset && (state == ISSUE);
    assign bus.m_write = attr_q.write;
    assign bus.m_addr  = addr_q;
    assign bus.m_len   = attr_q.len;
    assign bus.m_size  = attr_q.size;
    assign bus.m_burst = attr_q.burst;
    assign bus.m_id    = id_q;
    assign bus.m_src   = src_q;

    assign dbg_state = state;
endmodule
